prog_loader: RTL and testbench

//  Upstream feeder for u_utd: takes a byte stream (UART RX or host FIFO), parses a framed program image,

---
 rtl/prog_loader_pkg.sv | 37 +++
 rtl/prog_loader_if.sv | 22 ++
 rtl/prog_loader.sv | 187 ++++++++++++++++++
 tb/tb_prog_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants for the framed program loader: state codes, sync byte and
// the bit layout of the load_program word.
package prog_loader_pkg;

  typedef logic [3:0] state_t;

  // state   | meaning
  // IDLE    | waiting for SYNC, other bytes dropped
  // ADDR_HI | expecting start address high byte
  // ADDR_LO | expecting start address low byte
  // CNT_HI  | expecting word count high byte
  // CNT_LO  | expecting word count low byte
  // DATA_HI | expecting instruction high byte
  // DATA_LO | expecting instruction low byte
  // WRITE   | driving load_program strobe, input stalled
  // CHK     | expecting checksum byte (CHECKSUM_EN builds only)
  // DONE    | image loaded, CPU released
  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_ADDR_HI = 4'd1;
  localparam state_t ST_ADDR_LO = 4'd2;
  localparam state_t ST_CNT_HI  = 4'd3;
  localparam state_t ST_CNT_LO  = 4'd4;
  localparam state_t ST_DATA_HI = 4'd5;
  localparam state_t ST_DATA_LO = 4'd6;
  localparam state_t ST_WRITE   = 4'd7;
  localparam state_t ST_CHK     = 4'd8;
  localparam state_t ST_DONE    = 4'd9;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int LP_WR_BIT   = 31;
  localparam int LP_ADDR_MSB = 27;
  localparam int LP_ADDR_LSB = 16;
  localparam int LP_DATA_MSB = 15;
  localparam int LP_DATA_LSB = 0;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-input and program-load output bundle of prog_loader; the loader
// uses the slave view, the byte source / CPU side the master view.
interface prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [31:0] load_program;
  logic        cpu_hold;
  logic        start;
  logic        busy;
  logic        err;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, load_program, cpu_hold, start, busy, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, load_program, cpu_hold, start, busy, err
  );
endinterface

// File: rtl/prog_loader.sv
// Framed program-image loader: parses SYNC/addr/count/words from a byte stream,
// writes each word via load_program, then releases the CPU. Macro CHECKSUM_EN adds a trailing XOR check byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WR_HOLD = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus
);

  localparam int                HOLD_W    = $clog2(WR_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(WR_HOLD - 1);

`ifdef CHECKSUM_EN
  localparam state_t ST_LAST = ST_CHK;
`else
  localparam state_t ST_LAST = ST_DONE;
`endif

  state_t              state_q, state_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                start_q, start_d;
  logic                rx_fire;
  logic                sync_fire;
  logic [15:0]         rx_pair;

`ifdef CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                err_q, err_d;
`endif

  // Every state except WRITE consumes bytes; the source holds its byte while stalled.
  assign bus.rx_ready = !reset && (state_q != ST_WRITE);
  assign rx_fire      = bus.rx_valid && bus.rx_ready;
  assign sync_fire    = rx_fire && (bus.rx_data == SYNC_BYTE) &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign rx_pair      = {hi_q, bus.rx_data};

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    hold_d  = hold_q;
`ifdef CHECKSUM_EN
    csum_d  = csum_q;
    err_d   = err_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (sync_fire) state_d = ST_ADDR_HI;
      end
      ST_ADDR_HI: begin
        if (rx_fire) begin
          hi_d    = bus.rx_data;
          state_d = ST_ADDR_LO;
        end
      end
      ST_ADDR_LO: begin
        if (rx_fire) begin
          addr_d  = ADDR_W'(rx_pair);
          state_d = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (rx_fire) begin
          hi_d    = bus.rx_data;
          state_d = ST_CNT_LO;
        end
      end
      ST_CNT_LO: begin
        if (rx_fire) begin
          cnt_d   = rx_pair;
          state_d = (rx_pair == 16'd0) ? ST_LAST : ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (rx_fire) begin
          hi_d    = bus.rx_data;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (rx_fire) begin
          word_d  = DATA_W'(rx_pair);
          hold_d  = HOLD_LOAD;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // hold_q is a down-counter; terminal count ends the strobe
        if (hold_q == '0) begin
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - 16'd1;
          state_d = (cnt_q == 16'd1) ? ST_LAST : ST_DATA_HI;
        end else begin
          hold_d  = hold_q - HOLD_W'(1);
        end
      end
      ST_CHK: begin
`ifdef CHECKSUM_EN
        if (rx_fire) begin
          if (bus.rx_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef CHECKSUM_EN
    // Every byte between SYNC and the check byte folds into the running XOR.
    if (rx_fire && (state_q >= ST_ADDR_HI) && (state_q <= ST_DATA_LO))
      csum_d = csum_q ^ bus.rx_data;
    if (sync_fire) begin
      csum_d = '0;
      err_d  = 1'b0;
    end
`endif
  end

  assign start_d = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      hold_q  <= '0;
      start_q <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      hold_q  <= hold_d;
      start_q <= start_d;
`ifdef CHECKSUM_EN
      csum_q  <= csum_d;
      err_q   <= err_d;
`endif
    end
  end

  // Strobe is decoded from state so a reset drops it on the very next cycle.
  always_comb begin
    bus.load_program = '0;
    if (state_q == ST_WRITE) begin
      bus.load_program[LP_WR_BIT]               = 1'b1;
      bus.load_program[LP_ADDR_MSB:LP_ADDR_LSB] = addr_q;
      bus.load_program[LP_DATA_MSB:LP_DATA_LSB] = word_q;
    end
  end

  assign bus.cpu_hold = (state_q != ST_DONE);
  assign bus.busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.start    = start_q;
`ifdef CHECKSUM_EN
  assign bus.err      = err_q;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected writes and start
// pulses from a frame-level model; a negedge monitor pops and compares them.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int WR_HOLD = 2;

  logic clk = 1'b0;
  logic reset;

  prog_loader_if bus();

  prog_loader #(.WR_HOLD(WR_HOLD), .ADDR_W(12), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          gap    = 0;
  bit          skip_len = 1'b0;
  logic [31:0] exp_wr_q[$];
  int          exp_start_q[$];
  logic [15:0] words_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word i of a frame lands at (start address + i) mod 4096.
  function automatic logic [31:0] model_word(input logic [15:0] a16, input int i, input logic [15:0] w);
    int a;
    a = (int'(a16) + i) % 4096;
    return 32'h8000_0000 | (32'(a) << 16) | {16'h0000, w};
  endfunction

  initial begin : monitor
    logic [31:0] cur;
    int          run;
    bit          prev_wr;
    bit          prev_start;
    cur = '0; run = 0; prev_wr = 1'b0; prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.load_program[31]) begin
        if (!prev_wr) begin
          run = 1;
          checks++;
          if (exp_wr_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got %h expected no write", bus.load_program);
            cur = bus.load_program;
          end else begin
            cur = exp_wr_q.pop_front();
          end
        end else begin
          run++;
        end
        check("write_word", bus.load_program, cur);
        check("ready_in_write", 32'(bus.rx_ready), 32'd0);
        check("hold_in_write", 32'(bus.cpu_hold), 32'd1);
      end else begin
        check("load_program_idle", bus.load_program, 32'd0);
        if (prev_wr) begin
          if (skip_len) skip_len = 1'b0;
          else check("write_len", 32'(run), 32'(WR_HOLD));
        end
      end
      prev_wr = bus.load_program[31];

      if (bus.start) begin
        checks++;
        if (prev_start || exp_start_q.size() == 0) begin
          errors++;
          $display("FAIL start_pulse: got start=1 expected %s",
                   prev_start ? "single-cycle pulse" : "no start");
        end else begin
          void'(exp_start_q.pop_front());
        end
        check("cpu_hold_at_start", 32'(bus.cpu_hold), 32'd0);
        check("busy_at_start", 32'(bus.busy), 32'd0);
      end
      prev_start = bus.start;
    end
  end

  // Called at a negedge; returns at a negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int n;
    bit rdy;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    do begin
      rdy = bus.rx_ready;
      @(posedge clk);
      n++;
      if (!rdy) @(negedge clk);
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %h not accepted after %0d cycles, expected acceptance", b, n);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(0, gap)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] a16, input bit good);
    logic [7:0]  bq[$];
    logic [15:0] cnt;
`ifdef CHECKSUM_EN
    logic [7:0]  x;
`endif
    cnt = 16'(words_q.size());
    bq  = {a16[15:8], a16[7:0], cnt[15:8], cnt[7:0]};
    foreach (words_q[i]) begin
      bq.push_back(words_q[i][15:8]);
      bq.push_back(words_q[i][7:0]);
      exp_wr_q.push_back(model_word(a16, i, words_q[i]));
    end
`ifdef CHECKSUM_EN
    x = 8'h00;
    foreach (bq[i]) x ^= bq[i];
    bq.push_back(good ? x : ~x);
`endif
    send_byte(SYNC_BYTE);
    foreach (bq[i]) begin
      if (i == int'(bq.size()) - 1 && good) exp_start_q.push_back(1);
      send_byte(bq[i]);
    end
  endtask

  task automatic finish_frame(input bit good);
    repeat (4) @(negedge clk);
    check("writes_drained", 32'(exp_wr_q.size()), 32'd0);
    check("starts_drained", 32'(exp_start_q.size()), 32'd0);
    check("cpu_hold_end", 32'(bus.cpu_hold), good ? 32'd0 : 32'd1);
    check("busy_end", 32'(bus.busy), 32'd0);
`ifdef CHECKSUM_EN
    check("err_end", 32'(bus.err), good ? 32'd0 : 32'd1);
`else
    check("err_end", 32'(bus.err), 32'd0);
`endif
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of stimulus, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("rst_load_program", bus.load_program, 32'd0);
    check("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("idle_cpu_hold", 32'(bus.cpu_hold), 32'd1);

    // single word at 0x103
    words_q = {16'h0003};
    send_frame(16'h0103, 1'b1);
    finish_frame(1'b1);

    // three words from address 0
    words_q = {16'h7400, 16'h7300, 16'h7800};
    send_frame(16'h0000, 1'b1);
    finish_frame(1'b1);

    // address wraps from 0xFFF to 0x000
    words_q = {16'hBEEF, 16'h1234};
    send_frame(16'h0FFF, 1'b1);
    finish_frame(1'b1);

    // empty image
    words_q.delete();
    send_frame(16'h0123, 1'b1);
    finish_frame(1'b1);

    // reset during the first write cycle of a two-word frame
    exp_wr_q.push_back(model_word(16'h0040, 0, 16'h1111));
    skip_len = 1'b1;
    send_byte(SYNC_BYTE);
    send_byte(8'h00);
    send_byte(8'h40);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    bus.rx_data  = 8'h11;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    bus.rx_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_load_program", bus.load_program, 32'd0);
    check("abort_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("abort_writes_drained", 32'(exp_wr_q.size()), 32'd0);
    words_q = {16'hAAAA, 16'h5555};
    send_frame(16'h0040, 1'b1);
    finish_frame(1'b1);

`ifdef CHECKSUM_EN
    words_q = {16'h1234};
    send_frame(16'h0200, 1'b0);
    finish_frame(1'b0);
    send_frame(16'h0200, 1'b1);
    finish_frame(1'b1);
`endif

    // randomized frames with junk bytes, stalls and ignored address bits
    for (int f = 0; f < 25; f++) begin
      logic [7:0]  junk;
      logic [15:0] a16;
      int          n;
      gap = $urandom_range(0, 2);
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom);
        if (junk == SYNC_BYTE) junk = 8'h5A;
        send_byte(junk);
      end
      a16 = 16'($urandom);
      n   = $urandom_range(0, 4);
      words_q.delete();
      repeat (n) words_q.push_back(16'($urandom));
      send_frame(a16, 1'b1);
      finish_frame(1'b1);
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
